// File: rtl/nonce_result_arbiter.sv
// -----------------------------------------------------------------------------
// nonce_result_arbiter
//
// Collects golden nonces from NUM_CORES hasher cores and serialises them
// towards a single transmitter. Each core owns a one-entry pending register.
// A round-robin arbiter moves one pending nonce per cycle into a small result
// FIFO. A three-state transmit FSM hands FIFO words to the serial transmitter.
// When the nonce space is exhausted and no results remain, the FSM sends one
// all-zero word as a "need more work" report.
//
// Ports
//   hash_clk      : sole clock, all state updates on the rising edge
//   reset         : asynchronous, active-high reset
//   golden_valid  : per-core one-cycle pulse, a golden nonce was found
//   golden_nonce  : per-core nonce, core k in bits [32k+31:32k]
//   exhausted     : one-cycle pulse, the nonce space is used up
//   serial_busy   : transmitter busy
//   serial_send   : one-cycle pulse, start transmission of serial_word
//   serial_word   : word to transmit, held until the next issue
//   fifo_count    : current result FIFO occupancy
//   overflow      : sticky, a result was dropped
//   last_nonce    : last result nonce issued, for display
// -----------------------------------------------------------------------------
module nonce_result_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int FIFO_LOG2   = 3,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                    hash_clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    golden_valid,
  input  logic [32*NUM_CORES-1:0] golden_nonce,
  input  logic                    exhausted,
  input  logic                    serial_busy,
  output logic                    serial_send,
  output logic [31:0]             serial_word,
  output logic [FIFO_LOG2:0]      fifo_count,
  output logic                    overflow,
  output logic [31:0]             last_nonce
);

  localparam int DEPTH = 2 ** FIFO_LOG2;
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [NUM_CORES-1:0] pend_valid;
  logic [31:0]          pend_nonce [NUM_CORES];
  logic [PTR_W-1:0]     rr_ptr;

  logic [PTR_W-1:0]     sel_idx;
  logic                 sel_found;
  logic [PTR_W-1:0]     rr_next;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] drop;
  logic                 push;
  logic                 pop;

  logic [31:0]          fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [31:0]          fifo_head;

  logic                 exh_pend;
  tx_state_t            state;
  tx_state_t            state_next;
  logic [TMR_W-1:0]     ack_cnt;
  logic                 issue_pop;
  logic                 issue_exh;

  // ---------------------------------------------------------------------------
  // Round-robin search over pending cores, starting at rr_ptr
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_CORES;
      if (!sel_found && pend_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  assign fifo_full  = (fifo_count == (FIFO_LOG2 + 1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign pop        = issue_pop;

  // A full FIFO may still accept a word when the head leaves on the same edge.
  assign push    = sel_found && (!fifo_full || pop);
  assign grant   = push ? (NUM_CORES'(1) << sel_idx) : '0;
  assign rr_next = (sel_idx == PTR_W'(NUM_CORES - 1)) ? '0 : sel_idx + PTR_W'(1);

  // A new nonce is lost only if its slot is occupied and not leaving this cycle.
  assign drop = golden_valid & pend_valid & ~grant;

  // ---------------------------------------------------------------------------
  // Pending registers, overflow flag and round-robin pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      pend_valid <= '0;
      overflow   <= 1'b0;
      rr_ptr     <= '0;
      for (int k = 0; k < NUM_CORES; k++) pend_nonce[k] <= '0;
    end else begin
      pend_valid <= (pend_valid & ~grant) | golden_valid;
      overflow   <= overflow | (|drop);
      if (push) rr_ptr <= rr_next;
      for (int k = 0; k < NUM_CORES; k++) begin
        if (golden_valid[k] && !drop[k]) pend_nonce[k] <= golden_nonce[32*k +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge hash_clk) begin
    if (push) fifo_mem[wr_ptr] <= pend_nonce[sel_idx];
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_LOG2 + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_LOG2 + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Transmit FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue_pop || issue_exh) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (serial_busy)                                state_next = WAIT_DONE;
        else if (ack_cnt == TMR_W'(ACK_TIMEOUT - 1))    state_next = IDLE;
      end
      WAIT_DONE: begin
        if (!serial_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Transmit FSM: issue decisions. Results win over the exhausted report, and
  // the report also waits for nonces still sitting in pending registers.
  always_comb begin
    issue_pop = 1'b0;
    issue_exh = 1'b0;
    if (state == IDLE && !serial_busy) begin
      if (!fifo_empty)                      issue_pop = 1'b1;
      else if (!(|pend_valid) && exh_pend)  issue_exh = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers, exhausted flag and acknowledge timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      serial_send <= 1'b0;
      serial_word <= '0;
      last_nonce  <= '0;
      exh_pend    <= 1'b0;
      ack_cnt     <= '0;
    end else begin
      serial_send <= issue_pop | issue_exh;
      if (issue_pop) begin
        serial_word <= fifo_head;
        last_nonce  <= fifo_head;
      end else if (issue_exh) begin
        serial_word <= '0;
      end
      // A fresh exhausted pulse re-arms the report even on the clearing edge.
      exh_pend <= exhausted | (exh_pend & ~issue_exh);
      // Counts cycles spent in WAIT_ACK; the FSM leaves before it can wrap.
      if (state == WAIT_ACK) ack_cnt <= ack_cnt + TMR_W'(1);
      else                   ack_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nonce_result_arbiter
//
// Directed bench for nonce_result_arbiter with default parameters
// (4 cores, 8-entry FIFO, acknowledge timeout 4). Outputs are sampled on the
// falling edge; inputs change on the falling edge. An optional transmitter
// model raises serial_busy for two cycles after each send.
// -----------------------------------------------------------------------------
module tb_nonce_result_arbiter;

  logic         hash_clk = 1'b0;
  logic         reset    = 1'b1;
  logic [3:0]   golden_valid = '0;
  logic [127:0] golden_nonce = '0;
  logic         exhausted    = 1'b0;
  logic         serial_busy  = 1'b0;
  logic         serial_send;
  logic [31:0]  serial_word;
  logic [3:0]   fifo_count;
  logic         overflow;
  logic [31:0]  last_nonce;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit auto_busy = 1'b0;
  int busy_left = 0;
  logic [31:0] sent_q[$];
  int          send_cyc[$];

  nonce_result_arbiter #(
    .NUM_CORES  (4),
    .FIFO_LOG2  (3),
    .ACK_TIMEOUT(4)
  ) dut (
    .hash_clk    (hash_clk),
    .reset       (reset),
    .golden_valid(golden_valid),
    .golden_nonce(golden_nonce),
    .exhausted   (exhausted),
    .serial_busy (serial_busy),
    .serial_send (serial_send),
    .serial_word (serial_word),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .last_nonce  (last_nonce)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge, log any send, run the transmitter model.
  task automatic cycle();
    @(negedge hash_clk);
    cyc++;
    if (serial_send) begin
      sent_q.push_back(serial_word);
      send_cyc.push_back(cyc);
    end
    if (auto_busy) begin
      if (serial_send) busy_left = 2;
      if (busy_left > 0) begin
        serial_busy = 1'b1;
        busy_left--;
      end else begin
        serial_busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    golden_valid = '0;
    exhausted    = 1'b0;
    serial_busy  = 1'b0;
    auto_busy    = 1'b0;
    busy_left    = 0;
    cycle();
    cycle();
    reset = 1'b0;
    sent_q.delete();
    send_cyc.delete();
  endtask

  task automatic pulse(input int core, input logic [31:0] nonce);
    golden_valid[core]          = 1'b1;
    golden_nonce[32*core +: 32] = nonce;
    cycle();
    golden_valid = '0;
  endtask

  // Run until n sends are logged or the budget expires; the count is checked.
  task automatic wait_sends(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (sent_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, sent_q.size(), n);
  endtask

  initial begin
    int c0;

    // ---- reset state ----
    cycle();
    check("rst_send",     serial_send, 0);
    check("rst_word",     serial_word, 0);
    check("rst_count",    fifo_count,  0);
    check("rst_overflow", overflow,    0);
    check("rst_last",     last_nonce,  0);
    do_reset();

    // ---- single result, valid-to-send latency ----
    auto_busy = 1'b1;
    c0 = cyc;
    pulse(0, 32'h1234ABCD);
    cycle();
    check("lat_count", fifo_count, 1);
    check("lat_send_early", serial_send, 0);
    cycle();
    check("lat_send_cyc", cyc - c0, 3);
    check("lat_send", serial_send, 1);
    check("lat_word", serial_word, 32'h1234ABCD);
    check("lat_last", last_nonce, 32'h1234ABCD);
    cycle();
    check("lat_send_one_cycle", serial_send, 0);
    check("lat_word_hold", serial_word, 32'h1234ABCD);

    // ---- four cores in the same cycle ----
    do_reset();
    auto_busy    = 1'b1;
    golden_valid = 4'hF;
    golden_nonce = {32'd13, 32'd12, 32'd11, 32'd10};
    cycle();
    golden_valid = '0;
    wait_sends("rr_n", 4, 100);
    for (int i = 0; i < 4; i++) check($sformatf("rr_word%0d", i),
                                      (i < sent_q.size()) ? sent_q[i] : 32'hX, 32'(10 + i));
    check("rr_overflow", overflow, 0);

    // ---- busy held high, FIFO saturates, ninth result waits in pending ----
    do_reset();
    serial_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pulse(0, 32'(100 + i));
      cycle();
    end
    repeat (3) cycle();
    check("sat_count", fifo_count, 8);
    check("sat_overflow", overflow, 0);
    check("sat_nosend", sent_q.size(), 0);
    auto_busy = 1'b1;
    wait_sends("sat_n", 9, 200);
    for (int i = 0; i < 9; i++) check($sformatf("sat_word%0d", i),
                                      (i < sent_q.size()) ? sent_q[i] : 32'hX, 32'(100 + i));
    check("sat_overflow_end", overflow, 0);
    check("sat_count_end", fifo_count, 0);

    // ---- back-to-back pulses on a full path drop the second nonce ----
    do_reset();
    serial_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse(1, 32'(200 + i));
      cycle();
    end
    check("ovf_full", fifo_count, 8);
    check("ovf_before", overflow, 0);
    pulse(1, 32'd300);
    pulse(1, 32'd301);
    cycle();
    check("ovf_set", overflow, 1);
    auto_busy = 1'b1;
    wait_sends("ovf_n", 9, 200);
    check("ovf_word8", (sent_q.size() > 8) ? sent_q[8] : 32'hX, 32'd300);
    repeat (20) cycle();
    check("ovf_no_extra", sent_q.size(), 9);
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_reset", overflow, 0);

    // ---- exhausted report waits for queued results ----
    do_reset();
    serial_busy = 1'b1;
    pulse(2, 32'h51);
    cycle();
    pulse(2, 32'h52);
    exhausted = 1'b1;
    cycle();
    exhausted = 1'b0;
    repeat (3) cycle();
    check("exh_queued", fifo_count, 2);
    auto_busy = 1'b1;
    wait_sends("exh_n", 3, 100);
    check("exh_w0", (sent_q.size() > 0) ? sent_q[0] : 32'hX, 32'h51);
    check("exh_w1", (sent_q.size() > 1) ? sent_q[1] : 32'hX, 32'h52);
    check("exh_w2", (sent_q.size() > 2) ? sent_q[2] : 32'hX, 32'h0);
    repeat (30) cycle();
    check("exh_once", sent_q.size(), 3);

    // ---- acknowledge timeout, then reset during WAIT_DONE ----
    do_reset();
    golden_valid = 4'b0011;
    golden_nonce = {32'd0, 32'd0, 32'hBBBB0002, 32'hAAAA0001};
    cycle();
    golden_valid = '0;
    wait_sends("to_n", 2, 50);
    check("to_w0", (sent_q.size() > 0) ? sent_q[0] : 32'hX, 32'hAAAA0001);
    check("to_w1", (sent_q.size() > 1) ? sent_q[1] : 32'hX, 32'hBBBB0002);
    check("to_gap", (send_cyc.size() > 1) ? send_cyc[1] - send_cyc[0] : -1, 5);

    repeat (10) cycle();
    sent_q.delete();
    send_cyc.delete();
    pulse(0, 32'hC0C0C0C0);
    pulse(0, 32'hD0D0D0D0);
    wait_sends("mid_n", 1, 20);
    serial_busy = 1'b1;
    cycle();
    cycle();
    check("mid_word_before", serial_word, 32'hC0C0C0C0);
    reset = 1'b1;
    #1;
    check("mid_send",     serial_send, 0);
    check("mid_word",     serial_word, 0);
    check("mid_last",     last_nonce,  0);
    check("mid_count",    fifo_count,  0);
    check("mid_overflow", overflow,    0);
    cycle();
    reset       = 1'b0;
    serial_busy = 1'b0;
    sent_q.delete();
    repeat (20) cycle();
    check("mid_discard", sent_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
